mem_resp_mux: RTL and testbench

MEM_RESP_MUX -- requirements
Module: mem_resp_mux

---
 rtl/mem_map_pkg.sv | 41 ++++
 rtl/mem_resp_mux_if.sv | 31 +++
 rtl/pixel_fifo.sv | 66 ++++++
 rtl/mem_resp_mux.sv | 134 +++++++++++++
 tb/tb_mem_resp_mux.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
// mem_map_pkg : address map, region decode and register bit positions
// Revision    : 1.0
// ============================================================================
package mem_map_pkg;

    localparam logic [31:0] c_ctrl_base     = 32'h0006_0000;
    localparam logic [31:0] c_status_base   = 32'h0006_0004;
    localparam logic [31:0] c_pixel_base    = 32'h0006_0008;
    localparam logic [31:0] c_unmapped_base = 32'h0008_0000;

    localparam int c_ctrl_en        = 0;
    localparam int c_ctrl_flush     = 1;
    localparam int c_ctrl_irq_en    = 2;

    localparam int c_stat_nonempty  = 0;
    localparam int c_stat_full      = 1;
    localparam int c_stat_ovf       = 2;
    localparam int c_stat_count_lsb = 8;

    localparam logic [31:0] c_buserr_data = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        RAM      = 3'd0,
        CTRL     = 3'd1,
        STATUS   = 3'd2,
        PIXEL    = 3'd3,
        UNMAPPED = 3'd4
    } region_t;

    function automatic region_t decode_region(input logic [31:0] a);
        if (a < c_ctrl_base)          return RAM;
        else if (a < c_status_base)   return CTRL;
        else if (a < c_pixel_base)    return STATUS;
        else if (a < c_unmapped_base) return PIXEL;
        else                          return UNMAPPED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_mux_if.sv
`default_nettype none
// ============================================================================
// mem_resp_mux_if : CPU data bus, RAM return data and camera push handshake
// Revision        : 1.0
// ============================================================================
interface mem_resp_mux_if;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] write_data;
    logic [31:0] ram_rdata;
    logic [31:0] read_data;
    logic        read_valid;
    logic        bus_err;
    logic [31:0] ctrl;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        irq;

    modport slave (
        input  addr, mem_read, mem_write, write_data, ram_rdata, pix_data, pix_valid,
        output read_data, read_valid, bus_err, ctrl, pix_ready, irq
    );

    modport master (
        output addr, mem_read, mem_write, write_data, ram_rdata, pix_data, pix_valid,
        input  read_data, read_valid, bus_err, ctrl, pix_ready, irq
    );
endinterface
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// pixel_fifo : circular pixel buffer with push/pop/flush and occupancy count
// Revision   : 1.0
// ============================================================================
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    input  wire logic                       i_flush,
    output logic      [WIDTH-1:0]           o_head,
    output logic                            o_empty,
    output logic                            o_full,
    output logic      [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_full_count);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // A pop frees the slot this cycle, so a full FIFO can still take a push.
    assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_resp_mux.sv
`default_nettype none
// ============================================================================
// mem_resp_mux : CPU load/store response mux over RAM, camera regs and FIFO
// Option       : define MEM_RESP_BUSERR_EN for bus-error responses
// Revision     : 1.0
// ============================================================================
module mem_resp_mux
    import mem_map_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mem_resp_mux_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_t     w_region;
    logic        w_rd;
    logic        w_wr;
    logic        w_pop_req;
    logic        w_pop;
    logic        w_push;
    logic        w_pix_ready;
    logic        w_ovf_set;
    logic        w_empty;
    logic        w_full;
    logic [CW-1:0] w_count;
    logic [31:0] w_head;
    logic [31:0] w_status;
    logic [31:0] w_capt;

    logic        r_rd_pending;
    logic        r_rd_ram;
    logic [31:0] r_rd_hold;
    logic [31:0] r_ctrl;
    logic        r_ovf;
    logic        r_irq;

    assign w_region  = decode_region(bus.addr);
    assign w_wr      = bus.mem_write;
    assign w_rd      = bus.mem_read & ~bus.mem_write;
    assign w_pop_req = w_rd & (w_region == PIXEL);
    assign w_pop     = w_pop_req & ~w_empty & ~r_ctrl[c_ctrl_flush];

    // Ready stays up on a full FIFO while a pop is in flight so the pair overlaps.
    assign w_pix_ready = r_ctrl[c_ctrl_en] & (~w_full | w_pop);
    assign w_push      = bus.pix_valid & w_pix_ready;
    assign w_ovf_set   = bus.pix_valid & r_ctrl[c_ctrl_en] & w_full & ~w_pop;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (bus.pix_data),
        .i_pop   (w_pop_req),
        .i_flush (r_ctrl[c_ctrl_flush]),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_comb begin
        w_status = '0;
        w_status[c_stat_nonempty] = ~w_empty;
        w_status[c_stat_full]     = w_full;
        w_status[c_stat_ovf]      = r_ovf;
        w_status[c_stat_count_lsb +: 5] = 5'(w_count);
    end

    always_comb begin
        w_capt = '0;
        unique case (w_region)
            CTRL:     w_capt = r_ctrl;
            STATUS:   w_capt = w_status;
            PIXEL:    w_capt = w_empty ? 32'h0 : w_head;
`ifdef MEM_RESP_BUSERR_EN
            UNMAPPED: w_capt = c_buserr_data;
`else
            UNMAPPED: w_capt = 32'h0;
`endif
            default:  w_capt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pending <= 1'b0;
            r_rd_ram     <= 1'b0;
            r_rd_hold    <= '0;
            r_ctrl       <= '0;
            r_ovf        <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_rd_pending <= w_rd;
            r_rd_ram     <= w_rd & (w_region == RAM);
            r_rd_hold    <= w_rd ? w_capt : 32'h0;

            if (w_wr && (w_region == CTRL)) r_ctrl <= bus.write_data;
            else                            r_ctrl[c_ctrl_flush] <= 1'b0;

            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_wr && (w_region == STATUS) && bus.write_data[c_stat_ovf])
                r_ovf <= 1'b0;

            r_irq <= r_ctrl[c_ctrl_irq_en] & ~w_empty;
        end
    end

`ifdef MEM_RESP_BUSERR_EN
    logic r_bus_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_bus_err <= 1'b0;
        else       r_bus_err <= (bus.mem_read | bus.mem_write) & (w_region == UNMAPPED);
    end

    assign bus.bus_err = r_bus_err;
`else
    assign bus.bus_err = 1'b0;
`endif

    assign bus.read_valid = r_rd_pending;
    assign bus.read_data  = r_rd_pending ? (r_rd_ram ? bus.ram_rdata : r_rd_hold) : 32'h0;
    assign bus.ctrl       = r_ctrl;
    assign bus.pix_ready  = w_pix_ready;
    assign bus.irq        = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_mem_resp_mux.sv
`default_nettype none
// ============================================================================
// tb_mem_resp_mux : directed self-checking bench for mem_resp_mux
// Revision        : 1.0
// ============================================================================
module tb_mem_resp_mux;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_resp_mux_if bus_if ();

    mem_resp_mux #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr = a; bus_if.write_data = d; bus_if.mem_write = 1'b1;
        tick();
        bus_if.mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus_if.addr = a; bus_if.mem_read = 1'b1;
        tick();
        bus_if.mem_read = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        bus_if.pix_data = d; bus_if.pix_valid = 1'b1;
        tick();
        bus_if.pix_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus_if.addr = '0; bus_if.mem_read = 1'b0; bus_if.mem_write = 1'b0;
        bus_if.write_data = '0; bus_if.ram_rdata = '0;
        bus_if.pix_data = '0; bus_if.pix_valid = 1'b0;

        #3;
        chk("rst_read_valid", {31'b0, bus_if.read_valid}, 32'h0);
        chk("rst_read_data",  bus_if.read_data, 32'h0);
        chk("rst_bus_err",    {31'b0, bus_if.bus_err}, 32'h0);
        chk("rst_ctrl",       bus_if.ctrl, 32'h0);
        chk("rst_irq",        {31'b0, bus_if.irq}, 32'h0);
        chk("rst_pix_ready",  {31'b0, bus_if.pix_ready}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // RAM read, one-cycle latency, then idle cycle drops valid
        rd(32'h0000_0100);
        bus_if.ram_rdata = 32'h1234_5678;
        #1;
        chk("ram_valid", {31'b0, bus_if.read_valid}, 32'h1);
        chk("ram_data",  bus_if.read_data, 32'h1234_5678);
        tick();
        chk("idle_valid", {31'b0, bus_if.read_valid}, 32'h0);
        chk("idle_data",  bus_if.read_data, 32'h0);

        // Read and write together: write wins, no response
        bus_if.addr = 32'h0006_0000; bus_if.write_data = 32'h5;
        bus_if.mem_read = 1'b1; bus_if.mem_write = 1'b1;
        tick();
        bus_if.mem_read = 1'b0; bus_if.mem_write = 1'b0;
        chk("rw_valid", {31'b0, bus_if.read_valid}, 32'h0);
        chk("rw_ctrl",  bus_if.ctrl, 32'h5);
        chk("en_ready", {31'b0, bus_if.pix_ready}, 32'h1);

        push(32'hAA);
        chk("irq_lag", {31'b0, bus_if.irq}, 32'h0);
        push(32'hBB);
        chk("irq_set", {31'b0, bus_if.irq}, 32'h1);
        rd(32'h0006_0004);
        chk("status_2", bus_if.read_data, 32'h0000_0201);
        rd(32'h0006_0008);
        chk("pop_aa", bus_if.read_data, 32'hAA);
        rd(32'h0006_0008);
        chk("pop_bb", bus_if.read_data, 32'hBB);
        chk("irq_hold", {31'b0, bus_if.irq}, 32'h1);
        tick();
        chk("irq_fall", {31'b0, bus_if.irq}, 32'h0);
        rd(32'h0006_0008);
        chk("empty_valid", {31'b0, bus_if.read_valid}, 32'h1);
        chk("empty_data",  bus_if.read_data, 32'h0);

        // Fill, overflow, clear overflow
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        chk("full_ready", {31'b0, bus_if.pix_ready}, 32'h0);
        push(32'h55);
        rd(32'h0006_0004);
        chk("status_ovf", bus_if.read_data, 32'h0000_0407);
        wr(32'h0006_0004, 32'h4);
        rd(32'h0006_0004);
        chk("status_clr", bus_if.read_data, 32'h0000_0403);

        // Full: pop and push together
        bus_if.addr = 32'h0006_0008; bus_if.mem_read = 1'b1;
        bus_if.pix_data = 32'hCC; bus_if.pix_valid = 1'b1;
        #1;
        chk("pp_ready", {31'b0, bus_if.pix_ready}, 32'h1);
        tick();
        bus_if.mem_read = 1'b0; bus_if.pix_valid = 1'b0;
        chk("pp_pop", bus_if.read_data, 32'h11);
        rd(32'h0006_0004);
        chk("pp_status", bus_if.read_data, 32'h0000_0403);
        rd(32'h0006_0008); chk("drain_22", bus_if.read_data, 32'h22);
        rd(32'h0006_0008); chk("drain_33", bus_if.read_data, 32'h33);
        rd(32'h0006_0008); chk("drain_44", bus_if.read_data, 32'h44);
        rd(32'h0006_0008); chk("drain_cc", bus_if.read_data, 32'hCC);

        // Flush with three entries
        push(32'h1); push(32'h2); push(32'h3);
        wr(32'h0006_0000, 32'h3);
        chk("flush_ctrl_set", bus_if.ctrl, 32'h3);
        tick();
        chk("flush_ctrl_clr", bus_if.ctrl, 32'h1);
        rd(32'h0006_0004);
        chk("flush_status", bus_if.read_data, 32'h0);
        rd(32'h0006_0000);
        chk("ctrl_readback", bus_if.read_data, 32'h1);

        // Unmapped read
        rd(32'h0009_0000);
        chk("unm_valid", {31'b0, bus_if.read_valid}, 32'h1);
`ifdef MEM_RESP_BUSERR_EN
        chk("unm_err",  {31'b0, bus_if.bus_err}, 32'h1);
        chk("unm_data", bus_if.read_data, 32'hDEAD_BEEF);
`else
        chk("unm_err",  {31'b0, bus_if.bus_err}, 32'h0);
        chk("unm_data", bus_if.read_data, 32'h0);
`endif
        tick();
        chk("unm_err_pulse", {31'b0, bus_if.bus_err}, 32'h0);

        // Reset while a response is pending
        rd(32'h0006_0000);
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, bus_if.read_valid}, 32'h0);
        chk("midrst_ctrl",  bus_if.ctrl, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
